// File: rtl/codec_pkg.sv
// Shared constants for the emulated WM8731 control-port target: register map,
// reset defaults, FSM state encodings and the default device address.
package codec_pkg;

   localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;
   localparam int         NUM_REGS_DEFAULT = 10;

   localparam logic [6:0] R_LIN_L   = 7'd0;
   localparam logic [6:0] R_LIN_R   = 7'd1;
   localparam logic [6:0] R_HP_L    = 7'd2;
   localparam logic [6:0] R_HP_R    = 7'd3;
   localparam logic [6:0] R_ANALOG  = 7'd4;
   localparam logic [6:0] R_DIGITAL = 7'd5;
   localparam logic [6:0] R_POWER   = 7'd6;
   localparam logic [6:0] R_FORMAT  = 7'd7;
   localparam logic [6:0] R_SAMPLE  = 7'd8;
   localparam logic [6:0] R_ACTIVE  = 7'd9;
   localparam logic [6:0] R_RESET   = 7'd15;

   // Packed so that index 0 is R0; the rightmost element is R_LIN_L.
   localparam logic [9:0][8:0] REG_DEFAULTS = {
      9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
      9'h00A, 9'h079, 9'h079, 9'h097, 9'h097
   };

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_DEV       = 3'd1;
   localparam state_t ST_ACK_DEV   = 3'd2;
   localparam state_t ST_BYTE1     = 3'd3;
   localparam state_t ST_ACK1      = 3'd4;
   localparam state_t ST_BYTE2     = 3'd5;
   localparam state_t ST_ACK2      = 3'd6;
   localparam state_t ST_WAIT_STOP = 3'd7;

   // Registers beyond the WM8731 map default to zero.
   function automatic logic [8:0] reg_default(input int idx);
      if (idx >= 0 && idx < 10) return REG_DEFAULTS[idx[3:0]];
      else                      return 9'h000;
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Brings SCL and SDA into the clk domain and produces rise/fall pulses.
// Optional feature macro: I2C_GLITCH_FILTER_EN adds a 3-sample majority filter
// on each line after the synchroniser (2 clk extra latency, rejects 1-clk pulses).
module i2c_line_sync
   import codec_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_rise,
   output logic sda_fall
);

   logic [1:0] scl_sync;
   logic [1:0] sda_sync;
   logic       scl_lvl;
   logic       sda_lvl;
   logic       scl_prev;
   logic       sda_prev;

   // Two-flop synchroniser; resets to the idle (pulled-up) bus level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
      end else begin
         scl_sync <= {scl_sync[0], scl_i};
         sda_sync <= {sda_sync[0], sda_i};
      end
   end

`ifdef I2C_GLITCH_FILTER_EN
   logic [1:0] scl_hist;
   logic [1:0] sda_hist;
   logic       scl_filt;
   logic       sda_filt;

   // Majority of the current and two previous samples; a level must persist two clk to pass.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_hist <= 2'b11;
         sda_hist <= 2'b11;
         scl_filt <= 1'b1;
         sda_filt <= 1'b1;
      end else begin
         scl_hist <= {scl_hist[0], scl_sync[1]};
         sda_hist <= {sda_hist[0], sda_sync[1]};
         scl_filt <= maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
         sda_filt <= maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
      end
   end

   assign scl_lvl = scl_filt;
   assign sda_lvl = sda_filt;
`else
   assign scl_lvl = scl_sync[1];
   assign sda_lvl = sda_sync[1];
`endif

   // Previous-level registers for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_prev <= scl_lvl;
         sda_prev <= sda_lvl;
      end
   end

   assign scl      = scl_lvl;
   assign sda      = sda_lvl;
   assign scl_rise =  scl_lvl & ~scl_prev;
   assign scl_fall = ~scl_lvl &  scl_prev;
   assign sda_rise =  sda_lvl & ~sda_prev;
   assign sda_fall = ~sda_lvl &  sda_prev;

endmodule

// File: rtl/codec_i2c_target.sv
// Write-only I2C target emulating the WM8731 control port. Receives
// {dev, addr/data[8], data[7:0]} frames and stores them in a 9-bit register file.
// Optional feature macro: I2C_GLITCH_FILTER_EN (handled in i2c_line_sync).
module codec_i2c_target
   import codec_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
   parameter int         NUM_REGS = NUM_REGS_DEFAULT
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       wr_stb,
   output logic [6:0] wr_addr,
   output logic [8:0] wr_data,
   input  logic [3:0] rd_addr,
   output logic [8:0] rd_data,
   output logic       active,
   output logic       err_stb
);

   logic scl, sda, scl_rise, scl_fall, sda_rise, sda_fall;

   i2c_line_sync u_line_sync (
      .clk      (clk),
      .rst      (rst),
      .scl_i    (scl_i),
      .sda_i    (sda_i),
      .scl      (scl),
      .sda      (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .sda_rise (sda_rise),
      .sda_fall (sda_fall)
   );

   logic       start_det;
   logic       stop_det;
   state_t     state;
   logic [3:0] bit_cnt;
   logic [7:0] shreg;
   logic [7:0] byte1;
   logic [8:0] regs [NUM_REGS];
   logic [6:0] cmt_addr;
   logic [8:0] cmt_data;
   logic       addr_ok;
   logic       reset_cmd;
   logic       commit_fire;
   logic       byte_done;
   logic       shift_state;

   assign start_det   = sda_fall & scl;
   assign stop_det    = sda_rise & scl;
   assign cmt_addr    = byte1[7:1];
   assign cmt_data    = {byte1[0], shreg};
   assign addr_ok     = int'(cmt_addr) < NUM_REGS;
   assign reset_cmd   = (cmt_addr == R_RESET) && (cmt_data == 9'h000);
   assign commit_fire = (state == ST_ACK2) && scl_fall && !start_det && !stop_det;
   assign byte_done   = scl_fall && (bit_cnt == 4'd8);
   assign shift_state = (state == ST_DEV) || (state == ST_BYTE1) || (state == ST_BYTE2);

   // Frame sequencer: shifts bytes, drives ACKs after SCL falls, flags protocol errors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         bit_cnt <= 4'd0;
         shreg   <= 8'h00;
         byte1   <= 8'h00;
         sda_oe  <= 1'b0;
         err_stb <= 1'b0;
      end else begin
         err_stb <= 1'b0;
         if (start_det) begin
            state   <= ST_DEV;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
         end else if (stop_det) begin
            state   <= ST_IDLE;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
         end else if (shift_state) begin
            if (scl_rise && bit_cnt < 4'd8) begin
               shreg   <= {shreg[6:0], sda};
               bit_cnt <= bit_cnt + 4'd1;
            end else if (byte_done) begin
               bit_cnt <= 4'd0;
               if (state == ST_DEV) begin
                  if (shreg[7:1] != DEV_ADDR) begin
                     state <= ST_IDLE;
                  end else if (shreg[0]) begin
                     // Read request: NACK; bit_cnt=8 lets the NACK clock be absorbed.
                     err_stb <= 1'b1;
                     state   <= ST_WAIT_STOP;
                     bit_cnt <= 4'd8;
                  end else begin
                     sda_oe <= 1'b1;
                     state  <= ST_ACK_DEV;
                  end
               end else if (state == ST_BYTE1) begin
                  byte1  <= shreg;
                  sda_oe <= 1'b1;
                  state  <= ST_ACK1;
               end else begin
                  sda_oe <= 1'b1;
                  state  <= ST_ACK2;
               end
            end
         end else begin
            case (state)
               ST_ACK_DEV: begin
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                     state  <= ST_BYTE1;
                  end
               end
               ST_ACK1: begin
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                     state  <= ST_BYTE2;
                  end
               end
               ST_ACK2: begin
                  if (scl_fall) begin
                     sda_oe  <= 1'b0;
                     state   <= ST_WAIT_STOP;
                     bit_cnt <= 4'd0;
                     err_stb <= !(addr_ok || reset_cmd);
                  end
               end
               ST_WAIT_STOP: begin
                  if (scl_rise && bit_cnt < 4'd9) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     err_stb <= 1'b1;
                  end else if (scl_fall && bit_cnt == 4'd9) begin
                     bit_cnt <= 4'd0;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Register file: commits a complete frame at the end of ACK2, or reloads defaults.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= reg_default(i);
         wr_stb  <= 1'b0;
         wr_addr <= 7'd0;
         wr_data <= 9'h000;
      end else begin
         wr_stb <= 1'b0;
         if (commit_fire && (addr_ok || reset_cmd)) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (reset_cmd)                regs[i] <= reg_default(i);
               else if (cmt_addr == 7'(i))   regs[i] <= cmt_data;
            end
            wr_stb  <= 1'b1;
            wr_addr <= cmt_addr;
            wr_data <= cmt_data;
         end
      end
   end

   // Combinational read port; out-of-range addresses read as zero.
   always_comb begin
      rd_data = 9'h000;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_addr == 4'(i)) rd_data = regs[i];
      end
   end

   assign active = regs[int'(R_ACTIVE)][0];

endmodule
